mem_sram_access: RTL and testbench

- MEM-stage consumer of the EXE-stage outputs: the ALU result, the store data (valRm) and the memory enables.
- Turns LDR/STR requests into accesses on an external 16-bit asynchronous SRAM. Each 32-bit word takes two half-word accesses.
- Holds the pipeline via `freeze` until the access completes, then presents the loaded word to the MEM/WB register.
- Sits between the EXE/MEM pipeline register and the MEM/WB pipeline register. It also owns the SRAM pins.

---
 rtl/mem_sram_access_pkg.sv | 17 +
 rtl/mem_sram_access_sram_addr_map.sv | 25 ++
 rtl/mem_sram_access.sv | 126 ++++++++++++
 tb/tb_mem_sram_access.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sram_access_pkg.sv
// Shared definitions for the MEM-stage SRAM access block: FSM state codes,
// half-word select values and the data-memory base address.
package mem_sram_access_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_LO = 3'd1;
    localparam logic [2:0] ST_RD_HI = 3'd2;
    localparam logic [2:0] ST_WR_LO = 3'd3;
    localparam logic [2:0] ST_WR_HI = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic MEM_HALF_LO = 1'b0;
    localparam logic MEM_HALF_HI = 1'b1;

    localparam int unsigned MEM_BASE_ADDR = 1024;

endpackage

// File: rtl/mem_sram_access_sram_addr_map.sv
// Combinational translation of a CPU byte address into a 16-bit SRAM
// half-word address: {wordAddr, half}. Out-of-range addresses wrap.
module sram_addr_map
    import mem_sram_access_pkg::*;
#(
    parameter int unsigned BASE_ADDR = MEM_BASE_ADDR,
    parameter int unsigned SRAM_AW   = 18
) (
    input  logic [31:0]        aluResult,
    input  logic               half,
    output logic [SRAM_AW-1:0] sramAddr
);

    logic [31:0]        offset;
    logic [SRAM_AW-2:0] wordAddr;
    logic               unusedBits;

    assign offset   = aluResult - BASE_ADDR;
    assign wordAddr = offset[SRAM_AW:2];
    assign sramAddr = {wordAddr, half};

    // Byte-lane bits and the wrapped upper bits deliberately take no part.
    assign unusedBits = ^{offset[31:SRAM_AW+1], offset[1:0]};

endmodule

// File: rtl/mem_sram_access.sv
// MEM-stage LDR/STR engine: splits each 32-bit access into two half-word
// accesses on an asynchronous 16-bit SRAM and freezes the pipeline meanwhile.
module mem_sram_access
    import mem_sram_access_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = MEM_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memReadEn,
    input  logic               memWriteEn,
    input  logic [31:0]        aluResult,
    input  logic [31:0]        valRm,
    output logic [31:0]        memResult,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int              CNT_W    = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        lo_q, lo_d;
    logic [31:0]        memResult_q, memResult_d;

    logic               lastCnt;
    logic               inAccess;
    logic               isWrite;
    logic               isHi;
    logic [SRAM_AW-1:0] mappedAddr;

    assign lastCnt  = (cnt_q == CNT_LAST);
    assign isWrite  = (state_q == ST_WR_LO) || (state_q == ST_WR_HI);
    assign isHi     = (state_q == ST_RD_HI) || (state_q == ST_WR_HI);
    assign inAccess = isWrite || (state_q == ST_RD_LO) || (state_q == ST_RD_HI);

    sram_addr_map #(
        .BASE_ADDR (BASE_ADDR),
        .SRAM_AW   (SRAM_AW)
    ) u_addr_map (
        .aluResult (aluResult),
        .half      (isHi ? MEM_HALF_HI : MEM_HALF_LO),
        .sramAddr  (mappedAddr)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        memResult_d = memResult_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (memWriteEn) begin
                    state_d = ST_WR_LO;
                end else if (memReadEn) begin
                    state_d = ST_RD_LO;
                end
            end
            ST_RD_LO, ST_RD_HI, ST_WR_LO, ST_WR_HI: begin
                if (lastCnt) begin
                    cnt_d = '0;
                    case (state_q)
                        ST_RD_LO: begin
                            lo_d    = sram_dq_in;
                            state_d = ST_RD_HI;
                        end
                        ST_RD_HI: begin
                            memResult_d = {sram_dq_in, lo_q};
                            state_d     = ST_DONE;
                        end
                        ST_WR_LO: state_d = ST_WR_HI;
                        default:  state_d = ST_DONE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // One unfrozen cycle lets the pipeline move before the next request is seen.
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lo_q        <= '0;
            memResult_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            memResult_q <= memResult_d;
        end
    end

    // The last cycle of each write half keeps address and data valid with we_n high.
    always_comb begin
        freeze      = inAccess || ((state_q == ST_IDLE) && (memReadEn || memWriteEn));
        sram_addr   = inAccess ? mappedAddr : '0;
        sram_dq_oe  = isWrite;
        sram_dq_out = '0;
        if (isWrite) begin
            sram_dq_out = isHi ? valRm[31:16] : valRm[15:0];
        end
        sram_we_n   = !(isWrite && !lastCnt);
    end

    assign memResult = memResult_q;

endmodule

// File: tb/tb_mem_sram_access.sv
// Bench for mem_sram_access: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_sram_access;

    localparam int W    = 4;
    localparam int BASE = 1024;
    localparam int AW   = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          memReadEn = 1'b0;
    logic          memWriteEn = 1'b0;
    logic [31:0]   aluResult = '0;
    logic [31:0]   valRm = '0;
    logic [31:0]   memResult;
    logic          freeze;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] padMem [64];
    logic [15:0] refMem [64];

    bit          mBusy = 1'b0;
    int          mK = 0;
    bit          mWr = 1'b0;
    logic [31:0] mExp = '0;

    bit b2bWin = 1'b0;
    int addr2Cycles = 0;

    mem_sram_access #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W),
        .SRAM_AW     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memReadEn   (memReadEn),
        .memWriteEn  (memWriteEn),
        .aluResult   (aluResult),
        .valRm       (valRm),
        .memResult   (memResult),
        .freeze      (freeze),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM pad: reads are combinational, writes latch on we_n rising.
    assign sram_dq_in = sram_dq_oe ? 16'h0000 : padMem[sram_addr[5:0]];

    always @(posedge sram_we_n) begin
        if (rst && sram_dq_oe) begin
            padMem[sram_addr[5:0]] = sram_dq_out;
        end
    end

    function automatic logic [31:0] halfAddr(logic [31:0] a, int half);
        logic [31:0] word;
        word = ((a - 32'(BASE)) >> 2) & ((32'd1 << (AW - 1)) - 32'd1);
        return word * 32'd2 + 32'(half);
    endfunction

    function automatic logic [5:0] memIdx(logic [31:0] a, int half);
        return 6'(halfAddr(a, half));
    endfunction

    // Transaction model: mK counts cycles since the request was accepted;
    // 1..W low half, W+1..2W high half, 2W+1 the single unfrozen DONE cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mBusy <= 1'b0;
            mK    <= 0;
            mExp  <= '0;
        end else if (!mBusy) begin
            if (memWriteEn || memReadEn) begin
                mBusy <= 1'b1;
                mK    <= 1;
                mWr   <= memWriteEn;
            end
        end else if (mK == 2 * W + 1) begin
            mBusy <= 1'b0;
            mK    <= 0;
        end else begin
            if (mK == 2 * W) begin
                if (mWr) begin
                    refMem[memIdx(aluResult, 0)] <= valRm[15:0];
                    refMem[memIdx(aluResult, 1)] <= valRm[31:16];
                end else begin
                    mExp <= {refMem[memIdx(aluResult, 1)], refMem[memIdx(aluResult, 0)]};
                end
            end
            mK <= mK + 1;
        end
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareCycle();
        logic        expFreeze;
        logic        expWe;
        logic        expOe;
        logic        chkDq;
        logic [31:0] expAddr;
        logic [15:0] expDq;
        int          hi;
        int          j;
        expFreeze = mBusy ? (mK <= 2 * W) : (memReadEn || memWriteEn);
        expWe     = 1'b1;
        expOe     = 1'b0;
        chkDq     = 1'b1;
        expAddr   = '0;
        expDq     = '0;
        if (mBusy && mK <= 2 * W) begin
            hi      = (mK > W) ? 1 : 0;
            j       = (mK - 1) % W;
            expAddr = halfAddr(aluResult, hi);
            expOe   = mWr;
            expWe   = !(mWr && (j < W - 1));
            if (mWr) begin
                expDq = (hi == 1) ? valRm[31:16] : valRm[15:0];
            end else begin
                chkDq = 1'b0;
            end
        end
        checkOutput("cyc_freeze", 32'(freeze), 32'(expFreeze));
        checkOutput("cyc_we_n", 32'(sram_we_n), 32'(expWe));
        checkOutput("cyc_dq_oe", 32'(sram_dq_oe), 32'(expOe));
        checkOutput("cyc_addr", 32'(sram_addr), expAddr);
        if (chkDq) begin
            checkOutput("cyc_dq_out", 32'(sram_dq_out), 32'(expDq));
        end
        checkOutput("cyc_memResult", memResult, mExp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            compareCycle();
        end
    end

    always @(negedge clk) begin
        if (b2bWin && freeze && (sram_addr == 18'd2)) begin
            addr2Cycles++;
        end
    end

    task automatic applyStimulus(
        input  logic        wr,
        input  logic        rd,
        input  logic [31:0] addr,
        input  logic [31:0] data,
        output int          freezeCyc,
        output int          weLow,
        output int          oeCyc,
        output logic [31:0] loAddr,
        output logic [31:0] hiAddr,
        output logic [15:0] loDq,
        output logic [15:0] hiDq,
        output logic [31:0] doneResult
    );
        int idx;
        bit done;
        memWriteEn = wr;
        memReadEn  = rd;
        aluResult  = addr;
        valRm      = data;
        freezeCyc  = 0;
        weLow      = 0;
        oeCyc      = 0;
        loAddr     = '1;
        hiAddr     = '1;
        loDq       = '0;
        hiDq       = '0;
        doneResult = '0;
        idx        = 0;
        done       = 1'b0;
        while (!done && idx < 40) begin
            @(negedge clk);
            if (freeze) freezeCyc++;
            if (!sram_we_n) weLow++;
            if (sram_dq_oe) oeCyc++;
            if (idx == 1) begin
                loAddr = 32'(sram_addr);
                loDq   = sram_dq_out;
            end
            if (idx == W + 1) begin
                hiAddr = 32'(sram_addr);
                hiDq   = sram_dq_out;
            end
            if (!freeze) begin
                done       = 1'b1;
                doneResult = memResult;
            end
            idx++;
        end
        if (!done) begin
            checkOutput("accessTimeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        memWriteEn = 1'b0;
        memReadEn  = 1'b0;
    endtask

    initial begin
        int          fc, wl, oc;
        logic [31:0] la, ha, res;
        logic [15:0] ld, hd;

        for (int i = 0; i < 64; i++) begin
            padMem[i] = 16'h1000 + 16'(i);
            refMem[i] = 16'h1000 + 16'(i);
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_freeze", 32'(freeze), 32'd0);
        checkOutput("rst_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("rst_addr", 32'(sram_addr), 32'd0);
        checkOutput("rst_memResult", memResult, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] store 0xDEADBEEF to 1024");
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, fc, wl, oc, la, ha, ld, hd, res);
        checkOutput("st_freezeCycles", 32'(fc), 32'd9);
        checkOutput("st_weLowCycles", 32'(wl), 32'd6);
        checkOutput("st_oeCycles", 32'(oc), 32'd8);
        checkOutput("st_loAddr", la, 32'd0);
        checkOutput("st_loDq", 32'(ld), 32'h0000BEEF);
        checkOutput("st_hiAddr", ha, 32'd1);
        checkOutput("st_hiDq", 32'(hd), 32'h0000DEAD);
        checkOutput("st_memResult", res, 32'd0);

        $display("[TB] load from 1024");
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0, fc, wl, oc, la, ha, ld, hd, res);
        checkOutput("ld_freezeCycles", 32'(fc), 32'd9);
        checkOutput("ld_oeCycles", 32'(oc), 32'd0);
        checkOutput("ld_weLowCycles", 32'(wl), 32'd0);
        checkOutput("ld_result", res, 32'hDEADBEEF);

        $display("[TB] non-memory instruction");
        aluResult = 32'd2048;
        valRm     = 32'h55AA55AA;
        repeat (3) begin
            @(negedge clk);
            checkOutput("nop_freeze", 32'(freeze), 32'd0);
            checkOutput("nop_we_n", 32'(sram_we_n), 32'd1);
            checkOutput("nop_memResult", memResult, 32'hDEADBEEF);
        end
        @(posedge clk);
        #1;

        $display("[TB] both enables at 1032");
        applyStimulus(1'b1, 1'b1, 32'd1032, 32'h12345678, fc, wl, oc, la, ha, ld, hd, res);
        checkOutput("both_loAddr", la, 32'd4);
        checkOutput("both_hiAddr", ha, 32'd5);
        checkOutput("both_weLowCycles", 32'(wl), 32'd6);
        checkOutput("both_memResult", res, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b1, 32'd1032, 32'h0, fc, wl, oc, la, ha, ld, hd, res);
        checkOutput("both_readback", res, 32'h12345678);

        $display("[TB] back-to-back loads at 1028 and 1036");
        b2bWin = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'h0, fc, wl, oc, la, ha, ld, hd, res);
        checkOutput("b2b1_loAddr", la, 32'd2);
        checkOutput("b2b1_result", res, 32'h10031002);
        applyStimulus(1'b0, 1'b1, 32'd1036, 32'h0, fc, wl, oc, la, ha, ld, hd, res);
        b2bWin = 1'b0;
        checkOutput("b2b2_freezeCycles", 32'(fc), 32'd9);
        checkOutput("b2b2_loAddr", la, 32'd6);
        checkOutput("b2b2_result", res, 32'h10071006);
        checkOutput("b2b_addr2Cycles", 32'(addr2Cycles), 32'd4);

        $display("[TB] reset during WR_HI");
        memWriteEn = 1'b1;
        aluResult  = 32'd1024;
        valRm      = 32'hCAFEF00D;
        repeat (W + 3) @(negedge clk);
        checkOutput("abort_preWeLow", 32'(sram_we_n), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("abort_addr", 32'(sram_addr), 32'd0);
        checkOutput("abort_memResult", memResult, 32'd0);
        memWriteEn = 1'b0;
        #1;
        checkOutput("abort_freeze", 32'(freeze), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_freeze", 32'(freeze), 32'd0);
            checkOutput("post_we_n", 32'(sram_we_n), 32'd1);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
